// File: rtl/pipe_ctrl_if.sv
// Hazard/stall controller bundle: hazard inputs from the pipeline, enable and
// flush controls plus performance counters back to it.
interface pipe_ctrl_if #(
    parameter int REG_W = 4,
    parameter int CNT_W = 16
);
    logic             id_ex_memread;
    logic [REG_W-1:0] id_ex_rd;
    logic [REG_W-1:0] if_id_rs;
    logic [REG_W-1:0] if_id_rt;
    logic             if_id_uses_rt;
    logic             branch_taken;
    logic             halt_id;
    logic             icache_stall;
    logic             dcache_stall;

    logic             pc_wen;
    logic             if_id_wen;
    logic             id_ex_wen;
    logic             ex_mem_wen;
    logic             mem_wb_wen;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_ex_memread, id_ex_rd, if_id_rs, if_id_rt, if_id_uses_rt,
               branch_taken, halt_id, icache_stall, dcache_stall,
        input  pc_wen, if_id_wen, id_ex_wen, ex_mem_wen, mem_wb_wen,
               if_id_flush, id_ex_bubble, halted, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_ex_memread, id_ex_rd, if_id_rs, if_id_rt, if_id_uses_rt,
               branch_taken, halt_id, icache_stall, dcache_stall,
        output pc_wen, if_id_wen, id_ex_wen, ex_mem_wen, mem_wb_wen,
               if_id_flush, id_ex_bubble, halted, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Central hazard/stall controller for the 5-stage pipeline: zero-cycle
// combinational stall response, HLT drain sequencing and saturating counters.
module pipe_ctrl #(
    parameter int REG_W        = 4,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  bus
);
    localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   drain_q, drain_d;

    logic [REG_W-1:0] ex_rd, id_rs, id_rt;
    logic             luh;

    logic pc_wen_c, if_id_wen_c, id_ex_wen_c, ex_mem_wen_c, mem_wb_wen_c;
    logic if_id_flush_c, id_ex_bubble_c;

    assign ex_rd = bus.id_ex_rd;
    assign id_rs = bus.if_id_rs;
    assign id_rt = bus.if_id_rt;

    // Register 0 is hardwired, so a load targeting it can never create a hazard.
    assign luh = bus.id_ex_memread && (ex_rd != '0) &&
                 ((ex_rd == id_rs) || (bus.if_id_uses_rt && (ex_rd == id_rt)));

    always_comb begin
        state_d        = state_q;
        drain_d        = drain_q;
        pc_wen_c       = 1'b0;
        if_id_wen_c    = 1'b0;
        id_ex_wen_c    = 1'b0;
        ex_mem_wen_c   = 1'b0;
        mem_wb_wen_c   = 1'b0;
        if_id_flush_c  = 1'b0;
        id_ex_bubble_c = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (bus.dcache_stall) begin
                    // full freeze: every enable stays low
                end else if (luh || (bus.icache_stall && bus.branch_taken)) begin
                    // hold the branch in ID until its redirect fetch can start
                    id_ex_bubble_c = 1'b1;
                    id_ex_wen_c    = 1'b1;
                    ex_mem_wen_c   = 1'b1;
                    mem_wb_wen_c   = 1'b1;
                end else if (bus.branch_taken) begin
                    pc_wen_c       = 1'b1;
                    if_id_wen_c    = 1'b1;
                    id_ex_wen_c    = 1'b1;
                    ex_mem_wen_c   = 1'b1;
                    mem_wb_wen_c   = 1'b1;
                    if_id_flush_c  = 1'b1;
                end else if (bus.icache_stall) begin
                    if_id_wen_c    = 1'b1;
                    id_ex_wen_c    = 1'b1;
                    ex_mem_wen_c   = 1'b1;
                    mem_wb_wen_c   = 1'b1;
                    if_id_flush_c  = 1'b1;
                end else if (bus.halt_id) begin
                    id_ex_wen_c    = 1'b1;
                    ex_mem_wen_c   = 1'b1;
                    mem_wb_wen_c   = 1'b1;
                    drain_d        = DW'(DRAIN_CYCLES);
                    state_d        = ST_DRAIN;
                end else begin
                    pc_wen_c       = 1'b1;
                    if_id_wen_c    = 1'b1;
                    id_ex_wen_c    = 1'b1;
                    ex_mem_wen_c   = 1'b1;
                    mem_wb_wen_c   = 1'b1;
                end
            end
            ST_DRAIN: begin
                id_ex_bubble_c = 1'b1;
                id_ex_wen_c    = !bus.dcache_stall;
                ex_mem_wen_c   = !bus.dcache_stall;
                mem_wb_wen_c   = !bus.dcache_stall;
                if (!bus.dcache_stall) begin
                    if (drain_q == DW'(1)) begin
                        state_d = ST_HALTED;
                    end else begin
                        drain_d = drain_q - DW'(1);
                    end
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (rst) begin
            pc_wen_c       = 1'b0;
            if_id_wen_c    = 1'b0;
            id_ex_wen_c    = 1'b0;
            ex_mem_wen_c   = 1'b0;
            mem_wb_wen_c   = 1'b0;
            if_id_flush_c  = 1'b0;
            id_ex_bubble_c = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    // Counter 0 tracks PC stalls, counter 1 tracks IF_ID flushes; both freeze once halted.
    logic [1:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_all [2];

    assign cnt_inc[0] = (state_q != ST_HALTED) && !pc_wen_c;
    assign cnt_inc[1] = (state_q != ST_HALTED) && if_id_flush_c;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_q <= '0;
                end else if (cnt_inc[gi] && (cnt_q != '1)) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
            assign cnt_all[gi] = cnt_q;
        end
    endgenerate

    assign bus.pc_wen       = pc_wen_c;
    assign bus.if_id_wen    = if_id_wen_c;
    assign bus.id_ex_wen    = id_ex_wen_c;
    assign bus.ex_mem_wen   = ex_mem_wen_c;
    assign bus.mem_wb_wen   = mem_wb_wen_c;
    assign bus.if_id_flush  = if_id_flush_c;
    assign bus.id_ex_bubble = id_ex_bubble_c;
    assign bus.halted       = (state_q == ST_HALTED);
    assign bus.stall_cnt    = cnt_all[0];
    assign bus.flush_cnt    = cnt_all[1];
endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized traffic
// checked against a rule-level reference model.
module tb_pipe_ctrl;
    localparam int RW   = 4;
    localparam int CW   = 8;
    localparam int DC   = 3;
    localparam logic [CW-1:0] CMAX = {CW{1'b1}};
    localparam int M_RUN = 0, M_DRAIN = 1, M_HALTED = 2;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    pipe_ctrl_if #(.REG_W(RW), .CNT_W(CW)) bus ();

    pipe_ctrl #(.REG_W(RW), .DRAIN_CYCLES(DC), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // {pc, if_id, id_ex, ex_mem, mem_wb, flush, bubble}
    wire [6:0] act = {bus.pc_wen, bus.if_id_wen, bus.id_ex_wen, bus.ex_mem_wen,
                      bus.mem_wb_wen, bus.if_id_flush, bus.id_ex_bubble};

    // ---------------- reference model ----------------
    int              m_mode;
    int              m_left;
    logic [CW-1:0]   m_stall;
    logic [CW-1:0]   m_flush;
    logic            luh_m;
    logic [6:0]      exp_now;

    function automatic logic [6:0] model_ctrl(input logic r, input int mode,
                                              input logic luh, input logic br,
                                              input logic hl, input logic ic,
                                              input logic dc);
        if (r)                return 7'b0000000;
        if (mode == M_HALTED) return 7'b0000000;
        if (mode == M_DRAIN)  return {2'b00, {3{~dc}}, 2'b01};
        if (dc)               return 7'b0000000;
        if (luh || (ic && br)) return 7'b0011101;
        if (br)               return 7'b1111110;
        if (ic)               return 7'b0111110;
        if (hl)               return 7'b0011100;
        return 7'b1111100;
    endfunction

    assign luh_m = bus.id_ex_memread && (bus.id_ex_rd != 0) &&
                   ((bus.id_ex_rd == bus.if_id_rs) ||
                    (bus.if_id_uses_rt && (bus.id_ex_rd == bus.if_id_rt)));
    assign exp_now = model_ctrl(rst, m_mode, luh_m, bus.branch_taken, bus.halt_id,
                                bus.icache_stall, bus.dcache_stall);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode  <= M_RUN;
            m_left  <= 0;
            m_stall <= '0;
            m_flush <= '0;
        end else begin
            if (m_mode != M_HALTED) begin
                if (!exp_now[6] && m_stall != CMAX) m_stall <= m_stall + 1'b1;
                if (exp_now[1] && m_flush != CMAX)  m_flush <= m_flush + 1'b1;
            end
            if (m_mode == M_RUN) begin
                if (bus.halt_id && !bus.dcache_stall && !bus.branch_taken &&
                    !bus.icache_stall && !luh_m) begin
                    m_mode <= M_DRAIN;
                    m_left <= DC;
                end
            end else if (m_mode == M_DRAIN) begin
                if (!bus.dcache_stall) begin
                    if (m_left == 1) m_mode <= M_HALTED;
                    else             m_left <= m_left - 1;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        bus.id_ex_memread = 1'b0;
        bus.id_ex_rd      = '0;
        bus.if_id_rs      = '0;
        bus.if_id_rt      = '0;
        bus.if_id_uses_rt = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.halt_id       = 1'b0;
        bus.icache_stall  = 1'b0;
        bus.dcache_stall  = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle();
        bus.halt_id      = 1'b1;
        bus.branch_taken = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (act !== 7'b0000000) begin
            n_fail++; $display("FAIL reset_ctrl got=%b exp=%b", act, 7'b0000000);
        end
        n_tests++;
        if (bus.halted !== 1'b0 || bus.stall_cnt !== '0 || bus.flush_cnt !== '0) begin
            n_fail++; $display("FAIL reset_state halted=%b stall=%0d flush=%0d exp 0/0/0",
                               bus.halted, bus.stall_cnt, bus.flush_cnt);
        end
        idle();
        #1 rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (act !== 7'b1111100) begin
            n_fail++; $display("FAIL reset_release_run got=%b exp=%b", act, 7'b1111100);
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_load_use();
        do_reset();
        bus.id_ex_memread = 1'b1; bus.id_ex_rd = 4'd3; bus.if_id_rs = 4'd3;
        @(negedge clk);
        n_tests++;
        if (act !== 7'b0011101) begin
            n_fail++; $display("FAIL luh_rs got=%b exp=%b", act, 7'b0011101);
        end
        next_edge();
        n_tests++;
        if (bus.stall_cnt !== CW'(1)) begin
            n_fail++; $display("FAIL luh_stall_cnt got=%0d exp=1", bus.stall_cnt);
        end
        bus.id_ex_rd = 4'd0; bus.if_id_rs = 4'd0;
        @(negedge clk);
        n_tests++;
        if (act !== 7'b1111100) begin
            n_fail++; $display("FAIL luh_r0 got=%b exp=%b", act, 7'b1111100);
        end
        next_edge();
        bus.id_ex_rd = 4'd5; bus.if_id_rs = 4'd2; bus.if_id_rt = 4'd5; bus.if_id_uses_rt = 1'b1;
        @(negedge clk);
        n_tests++;
        if (act !== 7'b0011101) begin
            n_fail++; $display("FAIL luh_rt got=%b exp=%b", act, 7'b0011101);
        end
        bus.if_id_uses_rt = 1'b0;
        #1;
        n_tests++;
        if (act !== 7'b1111100) begin
            n_fail++; $display("FAIL luh_rt_unused got=%b exp=%b", act, 7'b1111100);
        end
        $display("[TB] test_load_use done");
    endtask

    task automatic test_branch();
        do_reset();
        bus.branch_taken = 1'b1;
        @(negedge clk);
        n_tests++;
        if (act !== 7'b1111110) begin
            n_fail++; $display("FAIL branch_ctrl got=%b exp=%b", act, 7'b1111110);
        end
        next_edge();
        n_tests++;
        if (bus.flush_cnt !== CW'(1) || bus.stall_cnt !== CW'(0)) begin
            n_fail++; $display("FAIL branch_cnt flush=%0d stall=%0d exp 1/0",
                               bus.flush_cnt, bus.stall_cnt);
        end
        $display("[TB] test_branch done");
    endtask

    task automatic test_icache_branch();
        do_reset();
        bus.icache_stall = 1'b1; bus.branch_taken = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_tests++;
            if (act !== 7'b0011101) begin
                n_fail++; $display("FAIL icbr_hold cyc=%0d got=%b exp=%b", k, act, 7'b0011101);
            end
            next_edge();
        end
        bus.icache_stall = 1'b0;
        @(negedge clk);
        n_tests++;
        if (act !== 7'b1111110) begin
            n_fail++; $display("FAIL icbr_redirect got=%b exp=%b", act, 7'b1111110);
        end
        next_edge();
        n_tests++;
        if (bus.flush_cnt !== CW'(1) || bus.stall_cnt !== CW'(4)) begin
            n_fail++; $display("FAIL icbr_cnt flush=%0d stall=%0d exp 1/4",
                               bus.flush_cnt, bus.stall_cnt);
        end
        $display("[TB] test_icache_branch done");
    endtask

    task automatic test_dcache_freeze();
        do_reset();
        bus.id_ex_memread = 1'b1; bus.id_ex_rd = 4'd7; bus.if_id_rs = 4'd7;
        bus.dcache_stall = 1'b1; bus.branch_taken = 1'b1;
        @(negedge clk);
        n_tests++;
        if (act !== 7'b0000000) begin
            n_fail++; $display("FAIL dfreeze got=%b exp=%b", act, 7'b0000000);
        end
        next_edge();
        bus.dcache_stall = 1'b0; bus.branch_taken = 1'b0;
        @(negedge clk);
        n_tests++;
        if (act !== 7'b0011101) begin
            n_fail++; $display("FAIL dfreeze_release got=%b exp=%b", act, 7'b0011101);
        end
        next_edge();
        n_tests++;
        if (bus.stall_cnt !== CW'(2) || bus.flush_cnt !== CW'(0)) begin
            n_fail++; $display("FAIL dfreeze_cnt stall=%0d flush=%0d exp 2/0",
                               bus.stall_cnt, bus.flush_cnt);
        end
        $display("[TB] test_dcache_freeze done");
    endtask

    task automatic test_halt_drain();
        logic [6:0] want;
        do_reset();
        bus.halt_id = 1'b1;
        @(negedge clk);
        n_tests++;
        if (act !== 7'b0011100) begin
            n_fail++; $display("FAIL halt_accept got=%b exp=%b", act, 7'b0011100);
        end
        next_edge();
        bus.halt_id = 1'b0;
        for (int k = 1; k <= DC + 2; k++) begin
            bus.dcache_stall = (k == 2 || k == 3);
            want = bus.dcache_stall ? 7'b0000001 : 7'b0011101;
            @(negedge clk);
            n_tests++;
            if (act !== want || bus.halted !== 1'b0) begin
                n_fail++; $display("FAIL drain_cyc%0d got=%b halted=%b exp=%b halted=0",
                                   k, act, bus.halted, want);
            end
            next_edge();
        end
        bus.dcache_stall = 1'b0;
        n_tests++;
        if (bus.halted !== 1'b1 || act !== 7'b0000000) begin
            n_fail++; $display("FAIL halted_rise halted=%b ctrl=%b exp 1/%b",
                               bus.halted, act, 7'b0000000);
        end
        n_tests++;
        if (bus.stall_cnt !== CW'(DC + 3) || bus.flush_cnt !== CW'(0)) begin
            n_fail++; $display("FAIL drain_cnt stall=%0d flush=%0d exp %0d/0",
                               bus.stall_cnt, bus.flush_cnt, DC + 3);
        end
        bus.branch_taken = 1'b1; bus.icache_stall = 1'b1;
        for (int k = 0; k < 5; k++) next_edge();
        n_tests++;
        if (bus.halted !== 1'b1 || act !== 7'b0000000 || bus.stall_cnt !== CW'(DC + 3) ||
            bus.flush_cnt !== CW'(0)) begin
            n_fail++; $display("FAIL halted_sticky halted=%b ctrl=%b stall=%0d flush=%0d exp 1/0000000/%0d/0",
                               bus.halted, act, bus.stall_cnt, bus.flush_cnt, DC + 3);
        end
        idle();
        $display("[TB] test_halt_drain done");
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.halt_id = 1'b1;
        next_edge();
        bus.halt_id = 1'b0;
        next_edge();
        n_tests++;
        if (act !== 7'b0011101 || bus.stall_cnt !== CW'(2)) begin
            n_fail++; $display("FAIL pre_areset ctrl=%b stall=%0d exp %b/2",
                               act, bus.stall_cnt, 7'b0011101);
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (act !== 7'b0000000 || bus.halted !== 1'b0 || bus.stall_cnt !== '0 ||
            bus.flush_cnt !== '0) begin
            n_fail++; $display("FAIL areset_now ctrl=%b halted=%b stall=%0d flush=%0d exp all 0",
                               act, bus.halted, bus.stall_cnt, bus.flush_cnt);
        end
        #1 rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (act !== 7'b1111100) begin
            n_fail++; $display("FAIL areset_run got=%b exp=%b", act, 7'b1111100);
        end
        for (int k = 0; k < 4; k++) next_edge();
        n_tests++;
        if (bus.halted !== 1'b0 || bus.stall_cnt !== '0 || act !== 7'b1111100) begin
            n_fail++; $display("FAIL areset_no_pending halted=%b stall=%0d ctrl=%b exp 0/0/%b",
                               bus.halted, bus.stall_cnt, act, 7'b1111100);
        end
        $display("[TB] test_async_reset done");
    endtask

    task automatic test_saturation();
        do_reset();
        bus.icache_stall = 1'b1;
        for (int k = 0; k < int'(CMAX) - 1; k++) next_edge();
        n_tests++;
        if (bus.stall_cnt !== CMAX - 1'b1 || bus.flush_cnt !== CMAX - 1'b1) begin
            n_fail++; $display("FAIL sat_pre stall=%0d flush=%0d exp %0d",
                               bus.stall_cnt, bus.flush_cnt, CMAX - 1'b1);
        end
        for (int k = 0; k < 40; k++) next_edge();
        n_tests++;
        if (bus.stall_cnt !== CMAX || bus.flush_cnt !== CMAX) begin
            n_fail++; $display("FAIL sat_hold stall=%0d flush=%0d exp %0d",
                               bus.stall_cnt, bus.flush_cnt, CMAX);
        end
        idle();
        $display("[TB] test_saturation done");
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            bus.id_ex_memread = ($urandom_range(0, 2) == 0);
            bus.id_ex_rd      = RW'($urandom_range(0, 3));
            bus.if_id_rs      = RW'($urandom_range(0, 3));
            bus.if_id_rt      = RW'($urandom_range(0, 3));
            bus.if_id_uses_rt = $urandom_range(0, 1) == 1;
            bus.branch_taken  = ($urandom_range(0, 3) == 0);
            bus.halt_id       = ($urandom_range(0, 12) == 0);
            bus.icache_stall  = ($urandom_range(0, 4) == 0);
            bus.dcache_stall  = ($urandom_range(0, 5) == 0);
            rst               = ($urandom_range(0, 70) == 0);
            @(negedge clk);
            n_tests++;
            if (act !== exp_now) begin
                n_fail++; errs++;
                $display("FAIL rand_ctrl cyc=%0d got=%b exp=%b", c, act, exp_now);
            end
            n_tests++;
            if (bus.halted !== (m_mode == M_HALTED) || bus.stall_cnt !== m_stall ||
                bus.flush_cnt !== m_flush) begin
                n_fail++; errs++;
                $display("FAIL rand_state cyc=%0d halted=%b stall=%0d flush=%0d exp %b/%0d/%0d",
                         c, bus.halted, bus.stall_cnt, bus.flush_cnt,
                         (m_mode == M_HALTED), m_stall, m_flush);
            end
            next_edge();
        end
        rst = 1'b0;
        idle();
        $display("[TB] test_random done, %0d cycle errors", errs);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b0;
        idle();
        #1;
        test_reset();
        test_load_use();
        test_branch();
        test_icache_branch();
        test_dcache_freeze();
        test_halt_drain();
        test_async_reset();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
